pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the RV32IM five-stage pipeline. It sits beside the ID and EX stages. It detects load-use hazards and flushes on taken branches and jumps. It also owns the multi-cycle DIV/DIVU/REM/REMU sequence: it starts the iterative divider, freezes the front of the pipeline for the divide latency, and releases it when the result is captured into EX/MEM.

---
 rtl/rv_pipe_pkg.sv | 13 +
 rtl/pipeline_hazard_ctrl_if.sv | 39 +++
 rtl/load_use_detect.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: hazard sequencer states, register-zero index
// and the NOP instruction loaded by the bubble and flush muxes.
package rv_pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } state_e;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID/EX hazard fields in, stall/flush/divide controls out.
interface pipeline_hazard_ctrl_if;

  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_is_div;
  logic       ex_branch_taken;

  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       ex_hold;
  logic       ex_mem_bubble;
  logic       div_start;
  logic       div_done;
  logic       div_busy;

  // Pipeline side: supplies stage fields, consumes the controls.
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rd, ex_mem_read, ex_is_div, ex_branch_taken,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
    input  ex_hold, ex_mem_bubble, div_start, div_done, div_busy
  );

  // Hazard controller side.
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rd, ex_mem_read, ex_is_div, ex_branch_taken,
    output pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
    output ex_hold, ex_mem_bubble, div_start, div_done, div_busy
  );

endinterface

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
module load_use_detect
  import rv_pipe_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use_c
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

  // Loads to x0 discard their data, so they never create a dependency.
  assign load_use_c = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, branch flushes and the
// multi-cycle divide freeze/release sequence. Controls are combinational.
module pipeline_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  pipeline_hazard_ctrl_if.slave   hz
);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_use;

  logic pc_stall, if_id_stall, if_id_flush, id_ex_bubble;
  logic ex_hold, ex_mem_bubble, div_start, div_done, div_busy;

  load_use_detect u_lu (
    .id_rs1      (hz.id_rs1),
    .id_rs2      (hz.id_rs2),
    .id_uses_rs1 (hz.id_uses_rs1),
    .id_uses_rs2 (hz.id_uses_rs2),
    .ex_rd       (hz.ex_rd),
    .ex_mem_read (hz.ex_mem_read),
    .load_use_c  (load_use)
  );

  // State and divide-latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and controls; priority is divide, then branch, then load-use.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_hold       = 1'b0;
    ex_mem_bubble = 1'b0;
    div_start     = 1'b0;
    div_done      = 1'b0;
    div_busy      = 1'b0;

    if (!rst) begin
      unique case (state)
        RUN: begin
          if (hz.ex_is_div) begin
            div_start     = 1'b1;
            div_busy      = 1'b1;
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            ex_hold       = 1'b1;
            ex_mem_bubble = 1'b1;
            cnt_nxt       = CNT_W'(DIV_CYCLES - 1);
            state_nxt     = DIV_WAIT;
          end else if (hz.ex_branch_taken) begin
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
          end else if (load_use) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_bubble  = 1'b1;
          end
        end

        DIV_WAIT: begin
          div_busy = 1'b1;
          if (cnt != '0) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            ex_hold       = 1'b1;
            ex_mem_bubble = 1'b1;
            cnt_nxt       = cnt - CNT_W'(1);
          end else begin
            // Release: EX/MEM captures the result; ex_is_div is not re-sampled.
            div_done  = 1'b1;
            state_nxt = RUN;
          end
        end

        default: state_nxt = RUN;
      endcase
    end
  end

  assign hz.pc_stall      = pc_stall;
  assign hz.if_id_stall   = if_id_stall;
  assign hz.if_id_flush   = if_id_flush;
  assign hz.id_ex_bubble  = id_ex_bubble;
  assign hz.ex_hold       = ex_hold;
  assign hz.ex_mem_bubble = ex_mem_bubble;
  assign hz.div_start     = div_start;
  assign hz.div_done      = div_done;
  assign hz.div_busy      = div_busy;

endmodule
